// File: rtl/asteroid_pkg.sv
// Shared constants, FSM encoding and sprite helpers for the asteroid renderer.
package asteroid_pkg;

    localparam logic [8:0]  SCREEN_W    = 9'd160;
    localparam logic [7:0]  SCREEN_H    = 8'd120;
    localparam int          SPRITE_W    = 4;
    localparam int          SPRITE_H    = 4;
    localparam logic [15:0] SPRITE_MASK = 16'b0110_1111_1111_0110;
    localparam logic [2:0]  BLACK       = 3'b000;
    localparam logic [2:0]  BG_COLOUR   = BLACK;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Opacity of the sprite pixel at raster index idx (dx = idx[1:0], dy = idx[3:2]).
    function automatic logic mask_bit(input logic [3:0] idx);
        return SPRITE_MASK[idx];
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// 4x4 raster scanner: walks the sprite cells and reports each cell's screen
// coordinate, opacity and whether it falls inside the visible area.
module sprite_scan
    import asteroid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [3:0] cnt,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       mask,
    output logic       on_screen
);

    logic [3:0] cnt_r;
    logic [8:0] sum_x_s;
    logic [7:0] sum_y_s;

    // Scan counter; wraps 15 -> 0 so the second pass restarts without a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (clr) begin
            cnt_r <= 4'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Widened sums so off-screen positions never alias back onto the screen.
    always_comb begin
        sum_x_s = {1'b0, base_x} + {7'd0, cnt_r[1:0]};
        sum_y_s = {1'b0, base_y} + {6'd0, cnt_r[3:2]};
    end

    assign cnt       = cnt_r;
    assign pix_x     = sum_x_s[7:0];
    assign pix_y     = sum_y_s[6:0];
    assign mask      = mask_bit(cnt_r);
    assign on_screen = (sum_x_s < SCREEN_W) && (sum_y_s < SCREEN_H);

endmodule

// File: rtl/asteroid_draw.sv
// Asteroid sprite renderer: erases the sprite at the old position, redraws it
// at the new one, one registered pixel per cycle to the VGA write port.
module asteroid_draw
    import asteroid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] old_x,
    input  logic [6:0] old_y,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    state_t     state_r, state_s;
    logic [7:0] old_x_r, new_x_r, base_x_s, pix_x_s, vga_x_r, vga_x_s;
    logic [6:0] old_y_r, new_y_r, base_y_s, pix_y_s, vga_y_r, vga_y_s;
    logic [2:0] colour_r, vga_colour_r, vga_colour_s;
    logic [3:0] cnt_s;
    logic       mask_s, on_screen_s, accept_s;
    logic       plot_r, plot_s, busy_r, busy_s, done_r, done_s;

    assign accept_s = (state_r == IDLE) && start;
    assign base_x_s = (state_r == DRAW) ? new_x_r : old_x_r;
    assign base_y_s = (state_r == DRAW) ? new_y_r : old_y_r;

    sprite_scan u_scan (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_r == IDLE),
        .en        ((state_r == ERASE) || (state_r == DRAW)),
        .base_x    (base_x_s),
        .base_y    (base_y_s),
        .cnt       (cnt_s),
        .pix_x     (pix_x_s),
        .pix_y     (pix_y_s),
        .mask      (mask_s),
        .on_screen (on_screen_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? ERASE : IDLE;
            ERASE:   state_s = (cnt_s == 4'd15) ? DRAW : ERASE;
            DRAW:    state_s = (cnt_s == 4'd15) ? FINISH : DRAW;
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values for the registered VGA port and status outputs.
    always_comb begin
        vga_x_s      = vga_x_r;
        vga_y_s      = vga_y_r;
        vga_colour_s = vga_colour_r;
        plot_s       = 1'b0;
        busy_s       = busy_r;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = start;
            end
            ERASE, DRAW: begin
                vga_x_s      = pix_x_s;
                vga_y_s      = pix_y_s;
                vga_colour_s = (state_r == DRAW) ? colour_r : BG_COLOUR;
                plot_s       = mask_s && on_screen_s;
                busy_s       = 1'b1;
            end
            FINISH: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'd0;
            plot_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            vga_x_r      <= vga_x_s;
            vga_y_r      <= vga_y_s;
            vga_colour_r <= vga_colour_s;
            plot_r       <= plot_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Request latches; only an accepted start may update them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_x_r  <= 8'd0;
            old_y_r  <= 7'd0;
            new_x_r  <= 8'd0;
            new_y_r  <= 7'd0;
            colour_r <= 3'd0;
        end else if (accept_s) begin
            old_x_r  <= old_x;
            old_y_r  <= old_y;
            new_x_r  <= new_x;
            new_y_r  <= new_y;
            colour_r <= colour;
        end else begin
            old_x_r  <= old_x_r;
            old_y_r  <= old_y_r;
            new_x_r  <= new_x_r;
            new_y_r  <= new_y_r;
            colour_r <= colour_r;
        end
    end

    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/asteroid_draw.md
# asteroid_draw

Sprite renderer sitting directly downstream of the asteroid motion stage: on each `start` it erases the 4x4 asteroid sprite at the previous position, then draws it at the new position. It streams one pixel per cycle to the VGA adapter's `x`/`y`/`colour`/`plot` write port on the 160x120 screen. Off-screen and transparent sprite pixels are suppressed. The motion stage's `new_x`/`new_y` and its previous position feed this block; `done` tells the game controller the frame update is complete.

## Interface
- `BG_COLOUR`, 3'b000: colour written during erase.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a frame update; sampled only in IDLE.
- `old_x`  in  8  previous sprite top-left x, 0..255.
- `old_y`  in  7  previous sprite top-left y, 0..127.
- `new_x`  in  8  new sprite top-left x.
- `new_y`  in  7  new sprite top-left y.
- `colour`  in  3  sprite colour for the draw pass.
- `vga_x`  out  8  pixel x to VGA adapter.
- `vga_y`  out  7  pixel y to VGA adapter.
- `vga_colour`  out  3  pixel colour.
- `plot`  out  1  write strobe; the adapter writes when high.
- `busy`  out  1  update in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ERASE, DRAW, FINISH.
- **IDLE:** on `start`=1, latch `old_x`, `old_y`, `new_x`, `new_y` and `colour`. Then go to ERASE with scan counter `cnt`=0 and `busy`=1.
- **ERASE:** for `cnt`=0..15:
  - dx=`cnt[1:0]`, dy=`cnt[3:2]`.
  - Present (old_x+dx, old_y+dy) in `BG_COLOUR`.
  - After `cnt`=15, go to DRAW with `cnt`=0.
- **DRAW:** same scan at (new_x+dx, new_y+dy) using the latched colour. After `cnt`=15, go to FINISH.
- **FINISH:** clear `busy`, pulse `done`, return to IDLE.
- Sprite mask: SPRITE_MASK=16'b0110_1111_1111_0110, indexed by `cnt`.
  - `plot`=0 for any pixel whose mask bit is 0.
  - Coordinates are still driven for that pixel.
- Clipping: sums are computed 9/8 bits wide, with no wrap-around. `plot`=0 whenever x sum ≥160 or y sum ≥120.
- `start` while `busy`=1, or in FINISH, is ignored. Inputs changing after latch have no effect.
- Reset (any time, including mid-scan) asynchronously forces:
  - IDLE, `cnt`=0, latches 0.
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - `plot`=0, `busy`=0, `done`=0.
  - A partially drawn sprite is left as-is.

## Timing
- All outputs are registered.
- `start` accepted at edge k: `busy`=1 after edge k.
- Erase pixel i is on the outputs after edge k+1+i (i=0..15).
- Draw pixel i is on the outputs after edge k+17+i.
- After edge k+33: `plot`=0, `busy`=0, `done`=1 for exactly one cycle.
- Next `start` can be accepted at edge k+34; total update period is 34 cycles.
- Exactly one pixel per cycle; there is no back-pressure from the adapter.

## Structure
- Shared package `asteroid_pkg`:
  - SCREEN_W=160, SCREEN_H=120.
  - SPRITE_W=4, SPRITE_H=4, SPRITE_MASK.
  - FSM state enum, colour constant BLACK.
- Sub-module `sprite_scan`:
  - Inputs: 4-bit counter with clear/enable, plus base x/y.
  - Outputs: offset coordinates, mask bit, on-screen flag.
  - Instantiated once and shared by ERASE and DRAW through a base-coordinate mux.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs 0 immediately, state IDLE; release → `plot` stays 0 until `start`.
- **Normal update:** old (10,20), new (11,20), colour 3'b111, `start` at edge k.
  - Erase: exactly 12 `plot` pulses, all colour 0; first plotted pixel (11,20) after edge k+2.
  - Draw: 12 `plot` pulses, colour 7.
  - `done` after edge k+33 only.
- **Clipping:** new (158,118) → draw pass plots only (159,118), (158,119), (159,119); no `plot` with `vga_x`≥160 or `vga_y`≥120.
- **Start while busy:** pulse `start` with new (50,50) at edges k+5 and k+33 → ignored; scan completes with the originally latched coordinates, single `done`.
- **Reset mid-draw:** assert `reset` after edge k+20 → `plot`, `busy` and `done` drop asynchronously; no `done` ever issued; fresh `start` runs a full 34-cycle update.
- **Back-to-back:** hold `start`=1 continuously → updates accepted at edges k, k+34, k+68, with one `done` per update.
